// File: rtl/vtracer_pkg.sv
// Shared raster constants, pixel-word layout and block geometry for the tracer read and write sides.
// Pure declarations; no timing or flow control.
package vtracer_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int BLOCK_SIZE  = 8;
    localparam int BLOCK_SHIFT = 3;
    localparam int COL_W       = 7;
    localparam int ROW_W       = 6;

    localparam int PIX_W     = 12;
    localparam int PIX_R_LSB = 8;
    localparam int PIX_G_LSB = 4;
    localparam int PIX_B_LSB = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic vblank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vblank: 1'b0};

    function automatic logic [CNT_W-1:0] block_of(input logic [CNT_W-1:0] cnt);
        return cnt >> BLOCK_SHIFT;
    endfunction

endpackage

// File: rtl/vga_block_scanner_sync_delay_line.sv
// Fixed-depth shift register that re-times stage-0 control flags to the pixel output.
// Latency DEPTH cycles; free-running, no stall.
module sync_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_block_scanner.sv
// VGA raster generator that reads one RAM word per 8x8 block and drives colour plus syncs.
// Counter-to-pin latency 2+RAM_LATENCY cycles; free-running, the RAM must keep up every cycle.
module vga_block_scanner
    import vtracer_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int RAM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] din,
    output logic [COL_W-1:0] col_addr,
    output logic [ROW_W-1:0] row_addr,
    output logic             rdn,
    output logic             hs,
    output logic             vs,
    output logic [3:0]       r,
    output logic [3:0]       g,
    output logic [3:0]       b,
    output logic             vblank_start
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // ---------------- stage 0: raster counters ----------------
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    logic  active0;
    sync_t sync0;

    always_comb begin
        active0      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        sync0.hs_n   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        sync0.vs_n   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        sync0.vblank = (h_cnt_q == '0) && (v_cnt_q == V_VIS);
    end

    // ---------------- stage 1: block address to RAM ----------------
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             rdn_q, rdn_d;

    always_comb begin
        col_d = '0;
        row_d = '0;
        rdn_d = 1'b1;
        if (active0) begin
            col_d = COL_W'(block_of(h_cnt_q));
            row_d = ROW_W'(block_of(v_cnt_q));
            rdn_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            rdn_q <= 1'b1;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            rdn_q <= rdn_d;
        end
    end

    // ---------------- alignment of control flags ----------------
    // The active flag gates the colour register, so it arrives one stage earlier than the syncs.
    logic  active_dly;
    sync_t sync_dly;

    sync_delay_line #(
        .WIDTH   (1),
        .DEPTH   (1 + RAM_LATENCY),
        .RST_VAL (1'b0)
    ) u_active_dly (
        .clk (clk),
        .rst (rst),
        .d_i (active0),
        .q_o (active_dly)
    );

    sync_delay_line #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (2 + RAM_LATENCY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d_i (sync0),
        .q_o (sync_dly)
    );

    // ---------------- colour register ----------------
    pixel_t pix_q, pix_d;

    always_comb begin
        pix_d = '0;
        if (active_dly) begin
            pix_d.r = din[PIX_R_LSB +: 4];
            pix_d.g = din[PIX_G_LSB +: 4];
            pix_d.b = din[PIX_B_LSB +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign col_addr     = col_q;
    assign row_addr     = row_q;
    assign rdn          = rdn_q;
    assign hs           = sync_dly.hs_n;
    assign vs           = sync_dly.vs_n;
    assign vblank_start = sync_dly.vblank;
    assign r            = pix_q.r;
    assign g            = pix_q.g;
    assign b            = pix_q.b;

endmodule

// File: tb/tb_vga_block_scanner.sv
// Directed bench: default-timing scanners at RAM latency 1 and 2 plus a shrunken-raster instance
// used for whole-frame timing, wrap and mid-frame reset scenarios.
module tb_vga_block_scanner;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vbs;
        logic       rdn;
        logic [6:0] col;
        logic [5:0] row;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } obs_t;

    localparam obs_t RST_OBS = '{hs: 1'b1, vs: 1'b1, vbs: 1'b0, rdn: 1'b1,
                                 col: 7'd0, row: 6'd0, r: 4'd0, g: 4'd0, b: 4'd0};

    // shrunken raster: 48 x 22 = 1056 cycles per frame
    localparam int S_HA = 32, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VA = 16, S_VF = 2, S_VS = 2, S_VB = 2;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    logic [11:0] din_a, din_b, din_s;
    logic [6:0]  a_col, b_col, s_col;
    logic [5:0]  a_row, b_row, s_row;
    logic        a_rdn, b_rdn, s_rdn, a_hs, b_hs, s_hs, a_vs, b_vs, s_vs, a_vbs, b_vbs, s_vbs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b, s_r, s_g, s_b;
    logic [11:0] ram_a_q1, ram_b_q1, ram_b_q2;

    obs_t obs_a, obs_b, obs_s;
    assign obs_a = {a_hs, a_vs, a_vbs, a_rdn, a_col, a_row, a_r, a_g, a_b};
    assign obs_b = {b_hs, b_vs, b_vbs, b_rdn, b_col, b_row, b_r, b_g, b_b};
    assign obs_s = {s_hs, s_vs, s_vbs, s_rdn, s_col, s_row, s_r, s_g, s_b};

    vga_block_scanner #(.RAM_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .col_addr(a_col), .row_addr(a_row), .rdn(a_rdn),
        .hs(a_hs), .vs(a_vs), .r(a_r), .g(a_g), .b(a_b), .vblank_start(a_vbs));

    vga_block_scanner #(.RAM_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .col_addr(b_col), .row_addr(b_row), .rdn(b_rdn),
        .hs(b_hs), .vs(b_vs), .r(b_r), .g(b_g), .b(b_b), .vblank_start(b_vbs));

    vga_block_scanner #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .RAM_LATENCY(1)
    ) dut_s (
        .clk(clk), .rst(rst), .din(din_s), .col_addr(s_col), .row_addr(s_row), .rdn(s_rdn),
        .hs(s_hs), .vs(s_vs), .r(s_r), .g(s_g), .b(s_b), .vblank_start(s_vbs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // RAM models: real block word while reading, all-ones garbage when rdn is high
    always @(posedge clk) begin
        ram_a_q1 <= a_rdn ? 12'hFFF : {b_dummy_row(a_row), 1'b0, a_col};
        ram_b_q1 <= b_rdn ? 12'hFFF : {b_dummy_row(b_row), 1'b0, b_col};
        ram_b_q2 <= ram_b_q1;
    end
    assign din_a = ram_a_q1;
    assign din_b = ram_b_q2;
    assign din_s = 12'hFFF;

    function automatic logic [3:0] b_dummy_row(input logic [5:0] row);
        return row[3:0];
    endfunction

    // Expected outputs after clock edge e (e=1 is the first edge after reset release).
    function automatic obs_t model(input int e, input int lat,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit fff);
        int   ht;
        int   vt;
        int   n;
        int   h;
        int   v;
        obs_t o;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        o  = RST_OBS;
        n  = e - 1;
        if (n >= 0) begin
            h = n % ht;
            v = (n / ht) % vt;
            if (h < ha && v < va) begin
                o.rdn = 1'b0;
                o.col = 7'(h / 8);
                o.row = 6'(v / 8);
            end
        end
        n = e - lat;
        if (n >= 0) begin
            h = n % ht;
            v = (n / ht) % vt;
            o.hs  = !(h >= ha + hf && h < ha + hf + hsw);
            o.vs  = !(v >= va + vf && v < va + vf + vsw);
            o.vbs = (h == 0) && (v == va);
            if (h < ha && v < va) begin
                if (fff) begin
                    o.r = 4'hF; o.g = 4'hF; o.b = 4'hF;
                end else begin
                    o.r = 4'(v / 8);
                    o.g = 4'((h / 8) / 16);
                    o.b = 4'((h / 8) % 16);
                end
            end
        end
        return o;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc reached=%0d wanted=%0d", cyc, t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_a !== RST_OBS) begin failures++; $display("FAIL reset_a got=%h exp=%h", obs_a, RST_OBS); end
        checks++;
        if (obs_b !== RST_OBS) begin failures++; $display("FAIL reset_b got=%h exp=%h", obs_b, RST_OBS); end
        checks++;
        if (obs_s !== RST_OBS) begin failures++; $display("FAIL reset_s got=%h exp=%h", obs_s, RST_OBS); end
        rst = 1'b0;
    endtask

    task automatic test_default_scan();
        obs_t ea;
        obs_t eb;
        do_reset();
        for (int k = 0; k < 7230; k++) begin
            @(negedge clk);
            ea = model(cyc, 3, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
            eb = model(cyc, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
            checks++;
            if (obs_a !== ea) begin failures++; $display("FAIL scan_lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, ea); end
            checks++;
            if (obs_b !== eb) begin failures++; $display("FAIL scan_lat2 cyc=%0d got=%h exp=%h", cyc, obs_b, eb); end
        end
    endtask

    task automatic test_line_wrap();
        do_reset();
        wait_cyc(640);
        checks++;
        if ({a_rdn, a_col, a_row} !== {1'b0, 7'd79, 6'd0}) begin
            failures++; $display("FAIL last_col got rdn=%b col=%0d row=%0d exp rdn=0 col=79 row=0", a_rdn, a_col, a_row);
        end
        wait_cyc(641);
        checks++;
        if ({a_rdn, a_col, a_row} !== {1'b1, 7'd0, 6'd0}) begin
            failures++; $display("FAIL blank_addr got rdn=%b col=%0d row=%0d exp rdn=1 col=0 row=0", a_rdn, a_col, a_row);
        end
        wait_cyc(658);
        checks++;
        if (a_hs !== 1'b1) begin failures++; $display("FAIL hs_before_fall got=%b exp=1", a_hs); end
        wait_cyc(659);
        checks++;
        if (a_hs !== 1'b0) begin failures++; $display("FAIL hs_fall_lat1 got=%b exp=0", a_hs); end
        checks++;
        if (b_hs !== 1'b1) begin failures++; $display("FAIL hs_fall_lat2_early got=%b exp=1", b_hs); end
        wait_cyc(754);
        checks++;
        if (a_hs !== 1'b0) begin failures++; $display("FAIL hs_last_low got=%b exp=0", a_hs); end
        wait_cyc(755);
        checks++;
        if (a_hs !== 1'b1) begin failures++; $display("FAIL hs_rise got=%b exp=1", a_hs); end
        wait_cyc(801);
        checks++;
        if ({a_rdn, a_col, a_row} !== {1'b0, 7'd0, 6'd0}) begin
            failures++; $display("FAIL line1_start got rdn=%b col=%0d row=%0d exp rdn=0 col=0 row=0", a_rdn, a_col, a_row);
        end
    endtask

    task automatic test_ram_read();
        do_reset();
        wait_cyc(7218);
        checks++;
        if ({a_rdn, a_col, a_row} !== {1'b0, 7'd2, 6'd1}) begin
            failures++; $display("FAIL addr_x17_y9 got rdn=%b col=%0d row=%0d exp rdn=0 col=2 row=1", a_rdn, a_col, a_row);
        end
        checks++;
        if ({a_r, a_g, a_b} !== 12'h101) begin failures++; $display("FAIL pix_x15_lat1 got=%h exp=101", {a_r, a_g, a_b}); end
        wait_cyc(7219);
        checks++;
        if ({b_r, b_g, b_b} !== 12'h101) begin failures++; $display("FAIL pix_x15_lat2 got=%h exp=101", {b_r, b_g, b_b}); end
        wait_cyc(7220);
        checks++;
        if ({a_r, a_g, a_b} !== 12'h102) begin failures++; $display("FAIL pix_x17_lat1 got=%h exp=102", {a_r, a_g, a_b}); end
        wait_cyc(7221);
        checks++;
        if ({b_r, b_g, b_b} !== 12'h102) begin failures++; $display("FAIL pix_x17_lat2 got=%h exp=102", {b_r, b_g, b_b}); end
    endtask

    // Two shrunken frames checked cycle by cycle, plus sync period/width and read-count measurements.
    task automatic scan_small_frames(input string tag);
        obs_t es;
        logic prev_hs, prev_vs;
        int   hs_fall, vs_fall, hs_per, vs_per, hs_low, vs_low, hs_w, vs_w, rd_cnt, vb_cnt;
        prev_hs = 1'b1; prev_vs = 1'b1;
        hs_fall = -1; vs_fall = -1; hs_per = 0; vs_per = 0;
        hs_low = 0; vs_low = 0; hs_w = 0; vs_w = 0; rd_cnt = 0; vb_cnt = 0;
        for (int k = 0; k < 2120; k++) begin
            @(negedge clk);
            es = model(cyc, 3, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1);
            checks++;
            if (obs_s !== es) begin failures++; $display("FAIL %s_cycle cyc=%0d got=%h exp=%h", tag, cyc, obs_s, es); end
            if (prev_hs && !s_hs) begin
                if (hs_fall >= 0) hs_per = cyc - hs_fall;
                hs_fall = cyc;
            end
            if (prev_vs && !s_vs) begin
                if (vs_fall >= 0) vs_per = cyc - vs_fall;
                vs_fall = cyc;
            end
            if (!s_hs) hs_low++;
            else if (hs_low != 0) begin hs_w = hs_low; hs_low = 0; end
            if (!s_vs) vs_low++;
            else if (vs_low != 0) begin vs_w = vs_low; vs_low = 0; end
            if (k < 1056 && !s_rdn) rd_cnt++;
            if (s_vbs) vb_cnt++;
            prev_hs = s_hs;
            prev_vs = s_vs;
        end
        checks++;
        if (hs_per != 48) begin failures++; $display("FAIL %s_hs_period got=%0d exp=48", tag, hs_per); end
        checks++;
        if (hs_w != 8) begin failures++; $display("FAIL %s_hs_width got=%0d exp=8", tag, hs_w); end
        checks++;
        if (vs_per != 1056) begin failures++; $display("FAIL %s_vs_period got=%0d exp=1056", tag, vs_per); end
        checks++;
        if (vs_w != 96) begin failures++; $display("FAIL %s_vs_width got=%0d exp=96", tag, vs_w); end
        checks++;
        if (rd_cnt != 512) begin failures++; $display("FAIL %s_read_count got=%0d exp=512", tag, rd_cnt); end
        checks++;
        if (vb_cnt != 2) begin failures++; $display("FAIL %s_vblank_count got=%0d exp=2", tag, vb_cnt); end
    endtask

    task automatic test_frame_timing();
        do_reset();
        scan_small_frames("frame");
    endtask

    task automatic test_async_reset();
        do_reset();
        wait_cyc(500);
        checks++;
        if (s_rdn !== 1'b0) begin failures++; $display("FAIL pre_reset_active got rdn=%b exp=0", s_rdn); end
        rst = 1'b1;
        #1;
        checks++;
        if (obs_s !== RST_OBS) begin failures++; $display("FAIL async_reset_s got=%h exp=%h", obs_s, RST_OBS); end
        checks++;
        if (obs_a !== RST_OBS) begin failures++; $display("FAIL async_reset_a got=%h exp=%h", obs_a, RST_OBS); end
        repeat (2) @(negedge clk);
        checks++;
        if (obs_s !== RST_OBS) begin failures++; $display("FAIL held_reset_s got=%h exp=%h", obs_s, RST_OBS); end
        rst = 1'b0;
        scan_small_frames("restart");
    endtask

    initial begin
        rst      = 1'b1;
        checks   = 0;
        failures = 0;
        test_reset();
        test_default_scan();
        test_line_wrap();
        test_ram_read();
        test_frame_timing();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
